// File: rtl/adc_seq_ctrl.sv
// Round-robin ADC conversion sequencer: arbitrates four channel requests, drives the SAR
// sample/start strobe and captures results. Optional CONV timeout via ADC_SEQ_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no conversion; arbitrate req starting at rr_ptr
// SAMPLE  | st_conv high for SAMPLE_CYC cycles, mux held on granted channel
// CONV    | wait for a fresh rising edge of synchronized adc_done (or timeout)
// CAPTURE | one-cycle data_valid strobe, then back to IDLE
module adc_seq_ctrl #(
  parameter int NCH         = 4,
  parameter int SAMPLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  output logic [NCH-1:0]  grant,
  output logic [1:0]      ch_sel,
  output logic            st_conv,
  input  logic            adc_done,
  input  logic [11:0]     adc_result,
  output logic [11:0]     data_out,
  output logic [1:0]      data_ch,
  output logic            data_valid,
  output logic            busy,
  output logic            timeout_err
);

  if (NCH != 4 || SAMPLE_CYC < 1 || SAMPLE_CYC > 15 ||
      TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_param
    $error("adc_seq_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, CAPTURE} state_t;

  state_t          state, state_d;
  logic [1:0]      rr_ptr, rr_d;
  logic [3:0]      samp_cnt, samp_d;
  logic [NCH-1:0]  grant_d;
  logic [1:0]      ch_d;
  logic [11:0]     out_d;
  logic [1:0]      dch_d;
  logic            dv_d, to_d;
  logic            done_s1, done_s2, done_s3;
  logic            done_rise;
  logic [1:0]      pick, cand;
  logic            pick_vld;

`ifdef ADC_SEQ_TIMEOUT_EN
  logic [7:0]      tmo_cnt, tmo_d;
`endif

  // done_s3 is only the edge-detect history; done_s1/done_s2 form the synchronizer
  assign done_rise = done_s2 & ~done_s3;

  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    cand     = 2'd0;
    // scan downward so the smallest offset from rr_ptr wins
    for (int i = 3; i >= 0; i--) begin
      cand = rr_ptr + 2'(i);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    rr_d    = rr_ptr;
    samp_d  = samp_cnt;
    grant_d = grant;
    ch_d    = ch_sel;
    out_d   = data_out;
    dch_d   = data_ch;
    dv_d    = 1'b0;
    to_d    = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
    tmo_d   = tmo_cnt;
`endif
    case (state)
      IDLE: begin
        grant_d = '0;
        if (pick_vld) begin
          state_d = SAMPLE;
          grant_d = NCH'(1) << pick;
          ch_d    = pick;
          samp_d  = 4'(SAMPLE_CYC - 1);
        end
      end
      SAMPLE: begin
        if (samp_cnt == 4'd0) begin
          state_d = CONV;
`ifdef ADC_SEQ_TIMEOUT_EN
          tmo_d   = 8'(TIMEOUT_CYC - 1);
`endif
        end else begin
          samp_d = samp_cnt - 4'd1;
        end
      end
      CONV: begin
        if (done_rise) begin
          state_d = CAPTURE;
          out_d   = adc_result;
          dch_d   = ch_sel;
          dv_d    = 1'b1;
          rr_d    = ch_sel + 2'd1;
`ifdef ADC_SEQ_TIMEOUT_EN
        end else if (tmo_cnt == 8'd0) begin
          state_d = CAPTURE;
          out_d   = 12'd0;
          dch_d   = ch_sel;
          dv_d    = 1'b1;
          to_d    = 1'b1;
          rr_d    = ch_sel + 2'd1;
        end else begin
          tmo_d = tmo_cnt - 8'd1;
`endif
        end
      end
      CAPTURE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 2'd0;
      samp_cnt    <= 4'd0;
      grant       <= '0;
      ch_sel      <= 2'd0;
      st_conv     <= 1'b0;
      data_out    <= 12'd0;
      data_ch     <= 2'd0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      done_s1     <= 1'b0;
      done_s2     <= 1'b0;
      done_s3     <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_d;
      samp_cnt    <= samp_d;
      grant       <= grant_d;
      ch_sel      <= ch_d;
      st_conv     <= (state_d == SAMPLE);
      data_out    <= out_d;
      data_ch     <= dch_d;
      data_valid  <= dv_d;
      busy        <= (state_d != IDLE);
      timeout_err <= to_d;
      done_s1     <= adc_done;
      done_s2     <= done_s1;
      done_s3     <= done_s2;
    end
  end

`ifdef ADC_SEQ_TIMEOUT_EN
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) tmo_cnt <= 8'd0;
    else     tmo_cnt <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl: stimulus pushes expected captures, a monitor pops
// and compares on every data_valid strobe.
module tb_adc_seq_ctrl;
  logic        clkin = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [1:0]  ch_sel;
  logic        st_conv;
  logic        adc_done;
  logic [11:0] adc_result;
  logic [11:0] data_out;
  logic [1:0]  data_ch;
  logic        data_valid;
  logic        busy;
  logic        timeout_err;

  adc_seq_ctrl #(.NCH(4), .SAMPLE_CYC(4), .TIMEOUT_CYC(64)) dut (
    .clkin(clkin), .rst(rst), .req(req), .grant(grant), .ch_sel(ch_sel),
    .st_conv(st_conv), .adc_done(adc_done), .adc_result(adc_result),
    .data_out(data_out), .data_ch(data_ch), .data_valid(data_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [11:0] d;
    logic [1:0]  ch;
    logic        to;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int nvalid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // monitor
  logic [11:0] last_d = 12'd0;
  logic [1:0]  last_ch = 2'd0;
  logic        prev_dv = 1'b0;
  always @(negedge clkin) begin
    exp_t e;
    if (rst) begin
      last_d  = 12'd0;
      last_ch = 2'd0;
      prev_dv = 1'b0;
    end else begin
      if (data_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_dv: data_valid with data_out=%0h data_ch=%0d, none expected",
                   data_out, data_ch);
        end else begin
          e = q.pop_front();
          check("data_out", 32'(data_out), 32'(e.d));
          check("data_ch", 32'(data_ch), 32'(e.ch));
          check("timeout_err", 32'(timeout_err), 32'(e.to));
        end
        check("dv_one_cycle", 32'(prev_dv), 32'd0);
        last_d  = data_out;
        last_ch = data_ch;
        nvalid++;
      end else begin
        if (data_out !== last_d || data_ch !== last_ch)
          check("data_hold", {18'd0, data_ch, data_out}, {18'd0, last_ch, last_d});
        if (timeout_err !== 1'b0)
          check("timeout_err_alone", 32'(timeout_err), 32'd0);
      end
      prev_dv = data_valid;
    end
  end

  task automatic wait_st_rise(output bit ok);
    int n = 0;
    @(negedge clkin);
    while (!st_conv && n < 10) begin
      @(negedge clkin);
      n++;
    end
    ok = st_conv;
    if (!ok) fail_now("st_conv_rise");
  endtask

  task automatic wait_st_fall(input bit drop, output int hi);
    hi = 0;
    while (st_conv && hi < 20) begin
      hi++;
      if (drop) req = 4'b0000;
      @(negedge clkin);
    end
  endtask

  task automatic wait_valid(input int v0, input string name);
    int n = 0;
    while (nvalid == v0 && n < 40) begin
      @(negedge clkin);
      n++;
    end
    if (nvalid == v0) fail_now(name);
  endtask

  task automatic conv(input logic [3:0] r, input logic [1:0] ch, input logic [11:0] res,
                      input int dly, input bit drop);
    exp_t e;
    bit   ok;
    int   hi;
    int   v0;
    e.d = res; e.ch = ch; e.to = 1'b0;
    q.push_back(e);
    req = r;
    wait_st_rise(ok);
    if (!ok) return;
    check("ch_sel_at_sample", 32'(ch_sel), 32'(ch));
    check("grant_at_sample", 32'(grant), 32'(4'b0001 << ch));
    wait_st_fall(drop, hi);
    check("st_conv_high_cycles", 32'(hi), 32'd4);
    check("grant_held_conv", 32'(grant), 32'(4'b0001 << ch));
    repeat (dly) @(negedge clkin);
    v0 = nvalid;
    adc_result = res;
    adc_done   = 1'b1;
    wait_valid(v0, "data_valid_wait");
    adc_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int hi;
    int v0;
    int n;
    exp_t e;
    rst = 1'b1; req = 4'b0000; adc_done = 1'b0; adc_result = 12'd0;
    repeat (3) @(negedge clkin);
    check("reset_outputs",
          {9'd0, grant, ch_sel, st_conv, data_out, data_ch, data_valid, busy, timeout_err},
          32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clkin);

    // single channel 2, result A5C, done 10 cycles after st_conv falls
    conv(4'b0100, 2'd2, 12'hA5C, 10, 1'b1);
    repeat (3) @(negedge clkin);
    check("idle_busy_after_ch2", 32'(busy), 32'd0);

    // channel 3 request dropped after first SAMPLE cycle still completes
    conv(4'b1000, 2'd3, 12'h7E1, 2, 1'b1);
    repeat (3) @(negedge clkin);
    check("idle_grant_after_drop", 32'(grant), 32'd0);
    check("idle_busy_after_drop", 32'(busy), 32'd0);

    // all four requesting: rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++)
      conv(4'b1111, 2'(i % 4), 12'h100 + 12'(i * 17), 1 + i, 1'b0);
    req = 4'b0000;
    repeat (4) @(negedge clkin);

    // done already high before CONV: only the second rise captures
    adc_result = 12'hBAD;
    adc_done   = 1'b1;
    repeat (5) @(negedge clkin);
    e.d = 12'h3C3; e.ch = 2'd0; e.to = 1'b0;
    q.push_back(e);
    v0  = nvalid;
    req = 4'b0001;
    wait_st_rise(ok);
    wait_st_fall(1'b1, hi);
    check("st_conv_high_stale_done", 32'(hi), 32'd4);
    repeat (3) @(negedge clkin);
    adc_done = 1'b0;
    repeat (5) @(negedge clkin);
    check("no_capture_on_stale_done", 32'(nvalid - v0), 32'd0);
    check("busy_waiting_fresh_rise", 32'(busy), 32'd1);
    adc_result = 12'h3C3;
    adc_done   = 1'b1;
    wait_valid(v0, "fresh_rise_capture");
    adc_done = 1'b0;
    repeat (3) @(negedge clkin);

    // reset 2 cycles into CONV aborts with no strobe
    req = 4'b0100;
    wait_st_rise(ok);
    check("ch_sel_before_abort", 32'(ch_sel), 32'd2);
    wait_st_fall(1'b1, hi);
    repeat (2) @(negedge clkin);
    v0 = nvalid;
    #1 rst = 1'b1;
    #1 check("async_reset_outputs",
             {9'd0, grant, ch_sel, st_conv, data_out, data_ch, data_valid, busy, timeout_err},
             32'd0);
    repeat (2) @(negedge clkin);
    rst = 1'b0;
    adc_result = 12'hFFF;
    adc_done   = 1'b1;
    repeat (8) @(negedge clkin);
    adc_done = 1'b0;
    repeat (4) @(negedge clkin);
    check("no_dv_after_abort", 32'(nvalid - v0), 32'd0);
    conv(4'b0010, 2'd1, 12'h5A5, 3, 1'b1);
    repeat (3) @(negedge clkin);

    // conversion that never gets adc_done, on channel 0
`ifdef ADC_SEQ_TIMEOUT_EN
    e.d = 12'd0; e.ch = 2'd0; e.to = 1'b1;
    q.push_back(e);
    req = 4'b0001;
    wait_st_rise(ok);
    wait_st_fall(1'b1, hi);
    n = 0;
    while (n < 100) begin
      @(negedge clkin);
      n++;
      if (data_valid) break;
    end
    check("timeout_conv_cycles", 32'(n), 32'd64);
    check("timeout_err_with_dv", {30'd0, data_valid, timeout_err}, 32'd3);
    repeat (2) @(negedge clkin);
    check("idle_after_timeout", 32'(busy), 32'd0);
`else
    req = 4'b0001;
    wait_st_rise(ok);
    wait_st_fall(1'b1, hi);
    repeat (80) @(negedge clkin);
    check("busy_no_timeout", 32'(busy), 32'd1);
    check("timeout_err_tied", 32'(timeout_err), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clkin);
    rst = 1'b0;
    repeat (2) @(negedge clkin);
`endif

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
